// File: rtl/iic_req_arbiter.sv
// iic_req_arbiter: round-robin share of one iic_host between two requesters.
// Latches one transaction, strobes iic_host, waits for done edge or timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN, rwN                request (held until doneN), 0=write 1=read
//   idN, addrN, wdataN       transaction fields from requester N
//   doneN, errN              one-cycle completion pulse, errN=1 on timeout
//   rdata                    read data, valid with doneN for reads
//   busy                     high from ISSUE through RELEASE
//   host_wr_en, host_rd_en   one-cycle strobes to iic_host
//   host_id/addr/wdata       latched fields, held until the next grant
//   host_wr_done/rd_done     iic_host completion (level or pulse)
//   host_rd_data             iic_host read data
module iic_req_arbiter #(
   parameter int               CNT_W       = 24,
   parameter logic [CNT_W-1:0] TIMEOUT_CYC = 24'd5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       rw0,
   input  logic       rw1,
   input  logic [7:0] id0,
   input  logic [7:0] id1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       done0,
   output logic       done1,
   output logic       err0,
   output logic       err1,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       host_wr_en,
   output logic       host_rd_en,
   output logic [7:0] host_id,
   output logic [7:0] host_addr,
   output logic [7:0] host_wdata,
   input  logic       host_wr_done,
   input  logic       host_rd_done,
   input  logic [7:0] host_rd_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT_CYC - CNT_W'(1);

   state_t           state;
   logic             gnt;
   logic             last_grant;
   logic             rw_q;
   logic [CNT_W-1:0] cnt;
   logic             wr_d;
   logic             rd_d;

   logic             wr_rise;
   logic             rd_rise;
   logic             hit;
   logic             pick1;
   logic             sel_rw;
   logic [7:0]       sel_id;
   logic [7:0]       sel_addr;
   logic [7:0]       sel_wdata;

   assign wr_rise = host_wr_done & ~wr_d;
   assign rd_rise = host_rd_done & ~rd_d;
   // only the edge matching the latched direction completes
   assign hit     = rw_q ? rd_rise : wr_rise;

   // on a tie the requester that was not served last wins
   always_comb begin
      pick1 = 1'b0;
      unique case (1'b1)
         req0 & req1:  pick1 = ~last_grant;
         req1 & ~req0: pick1 = 1'b1;
         default:      pick1 = 1'b0;
      endcase
      sel_rw    = pick1 ? rw1    : rw0;
      sel_id    = pick1 ? id1    : id0;
      sel_addr  = pick1 ? addr1  : addr0;
      sel_wdata = pick1 ? wdata1 : wdata0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         last_grant <= 1'b1;
         rw_q       <= 1'b0;
         cnt        <= '0;
         wr_d       <= 1'b0;
         rd_d       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata      <= 8'h00;
         busy       <= 1'b0;
         host_wr_en <= 1'b0;
         host_rd_en <= 1'b0;
         host_id    <= 8'h00;
         host_addr  <= 8'h00;
         host_wdata <= 8'h00;
      end else begin
         wr_d <= host_wr_done;
         rd_d <= host_rd_done;
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  gnt        <= pick1;
                  last_grant <= pick1;
                  rw_q       <= sel_rw;
                  host_id    <= sel_id;
                  host_addr  <= sel_addr;
                  host_wdata <= sel_wdata;
                  host_wr_en <= ~sel_rw;
                  host_rd_en <= sel_rw;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               host_wr_en <= 1'b0;
               host_rd_en <= 1'b0;
               cnt        <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               if (hit) begin
                  done0 <= ~gnt;
                  done1 <= gnt;
                  err0  <= 1'b0;
                  err1  <= 1'b0;
                  if (rw_q) begin
                     rdata <= host_rd_data;
                  end
                  state <= RELEASE;
               end else if (cnt == TO_LAST) begin
                  done0 <= ~gnt;
                  done1 <= gnt;
                  err0  <= ~gnt;
                  err1  <= gnt;
                  state <= RELEASE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iic_req_arbiter.sv
// tb_iic_req_arbiter: directed stimulus, timestamp-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_iic_req_arbiter;

   localparam int TO = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1, rw0, rw1;
   logic [7:0] id0, id1, addr0, addr1, wdata0, wdata1;
   logic       done0, done1, err0, err1, busy;
   logic [7:0] rdata;
   logic       host_wr_en, host_rd_en;
   logic [7:0] host_id, host_addr, host_wdata;
   logic       host_wr_done, host_rd_done;
   logic [7:0] host_rd_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iic_req_arbiter #(
      .CNT_W      (24),
      .TIMEOUT_CYC(24'd100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req0        (req0),
      .req1        (req1),
      .rw0         (rw0),
      .rw1         (rw1),
      .id0         (id0),
      .id1         (id1),
      .addr0       (addr0),
      .addr1       (addr1),
      .wdata0      (wdata0),
      .wdata1      (wdata1),
      .done0       (done0),
      .done1       (done1),
      .err0        (err0),
      .err1        (err1),
      .rdata       (rdata),
      .busy        (busy),
      .host_wr_en  (host_wr_en),
      .host_rd_en  (host_rd_en),
      .host_id     (host_id),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_wr_done(host_wr_done),
      .host_rd_done(host_rd_done),
      .host_rd_data(host_rd_data)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: a transaction is described by its ISSUE cycle and
   // the cycle its done pulse is visible; outputs follow from those.
   bit         started = 0;
   int         cyc = 0;
   bit         act, fin, trw, tg, terr, last;
   int         t_iss, t_done, age;
   logic       prev_w, prev_r, rise_w, rise_r;
   logic       e_wr_en, e_rd_en, e_busy, e_done0, e_done1, e_err0, e_err1;
   logic [7:0] e_id, e_addr, e_wdata, e_rdata;

   always @(posedge clk) begin
      if (rst) begin
         act = 0; fin = 0; last = 1; terr = 0; tg = 0; trw = 0;
         prev_w = 0; prev_r = 0;
         e_id = 0; e_addr = 0; e_wdata = 0; e_rdata = 0;
      end else begin
         rise_w = host_wr_done & ~prev_w;
         rise_r = host_rd_done & ~prev_r;
         prev_w = host_wr_done;
         prev_r = host_rd_done;
         if (act && fin && cyc == t_done) begin
            act = 0;
            fin = 0;
         end else if (act && !fin && cyc > t_iss) begin
            age = cyc - t_iss - 1;
            if (trw ? rise_r : rise_w) begin
               fin = 1; t_done = cyc + 1; terr = 0;
               if (trw) e_rdata = host_rd_data;
            end else if (age == TO - 1) begin
               fin = 1; t_done = cyc + 1; terr = 1;
            end
         end else if (!act && (req0 || req1)) begin
            tg      = (req0 && req1) ? !last : req1;
            last    = tg;
            trw     = tg ? rw1 : rw0;
            e_id    = tg ? id1 : id0;
            e_addr  = tg ? addr1 : addr0;
            e_wdata = tg ? wdata1 : wdata0;
            act     = 1;
            fin     = 0;
            t_iss   = cyc + 1;
         end
      end
      e_wr_en = act && (cyc + 1 == t_iss) && !trw;
      e_rd_en = act && (cyc + 1 == t_iss) && trw;
      e_busy  = act;
      e_done0 = act && fin && (cyc + 1 == t_done) && !tg;
      e_done1 = act && fin && (cyc + 1 == t_done) && tg;
      e_err0  = e_done0 && terr;
      e_err1  = e_done1 && terr;
      cyc++;
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_wr_en", host_wr_en, e_wr_en);
         chk("m_rd_en", host_rd_en, e_rd_en);
         chk("m_busy", busy, e_busy);
         chk("m_done0", done0, e_done0);
         chk("m_done1", done1, e_done1);
         chk("m_err0", err0, e_err0);
         chk("m_err1", err1, e_err1);
         chk("m_id", host_id, e_id);
         chk("m_addr", host_addr, e_addr);
         chk("m_wdata", host_wdata, e_wdata);
         chk("m_rdata", rdata, e_rdata);
      end
   end

   function automatic logic sig_of(input int w);
      case (w)
         0:       return host_wr_en;
         1:       return host_rd_en;
         2:       return done0;
         3:       return done1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int which, input int maxc,
                           input string name, output int n);
      bit hit;
      hit = 0;
      n = 0;
      while (!hit && n < maxc) begin
         @(negedge clk);
         n++;
         hit = sig_of(which);
      end
      chk(name, hit, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1;
      req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
      id0 = 0; id1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      host_wr_done = 0; host_rd_done = 0; host_rd_data = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_busy", busy, 0);
      chk("rst_id", host_id, 0);

      // single write from requester 0
      req0 = 1; rw0 = 0; id0 = 8'h53; addr0 = 8'h36; wdata0 = 8'hA5;
      wait_for(0, 5, "t1_strobe", n);
      chk("t1_lat", n, 1);
      chk("t1_id", host_id, 8'h53);
      chk("t1_addr", host_addr, 8'h36);
      chk("t1_wdata", host_wdata, 8'hA5);
      @(negedge clk);
      chk("t1_pulse", host_wr_en, 0);
      repeat (19) @(negedge clk);
      host_wr_done = 1;
      @(negedge clk);
      chk("t1_done0", done0, 1);
      chk("t1_err0", err0, 0);
      chk("t1_busy", busy, 1);
      req0 = 0;
      @(negedge clk);
      chk("t1_busy_fall", busy, 0);
      chk("t1_done_fall", done0, 0);
      host_wr_done = 0;

      // single read from requester 1
      req1 = 1; rw1 = 1; id1 = 8'h48; addr1 = 8'h10;
      wait_for(1, 5, "t2_strobe", n);
      chk("t2_addr", host_addr, 8'h10);
      repeat (5) @(negedge clk);
      host_rd_data = 8'h3C;
      host_rd_done = 1;
      @(negedge clk);
      chk("t2_done1", done1, 1);
      chk("t2_rdata", rdata, 8'h3C);
      chk("t2_err1", err1, 0);
      req1 = 0; rw1 = 0;
      @(negedge clk);
      host_rd_done = 0;
      host_rd_data = 0;

      // tie after reset, both held: 0,1,0,1
      rst = 1;
      @(negedge clk);
      rst = 0;
      req0 = 1; req1 = 1; id0 = 8'hA0; id1 = 8'hB1;
      for (int i = 0; i < 4; i++) begin
         wait_for(0, 8, "t3_strobe", n);
         chk("t3_order", host_id, (i % 2) ? 8'hB1 : 8'hA0);
         repeat (3) @(negedge clk);
         host_wr_done = 1;
         @(negedge clk);
         chk("t3_done", {done1, done0}, (i % 2) ? 2 : 1);
         host_wr_done = 0;
         if (i == 3) begin
            req0 = 0;
            req1 = 0;
         end
      end

      // timeout with no host done
      @(negedge clk);
      req0 = 1; id0 = 8'h11;
      wait_for(0, 5, "t4_strobe", n);
      n = 0;
      while (!done0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t4_cycles", n, 101);
      chk("t4_err0", err0, 1);
      req0 = 0;
      repeat (2) @(negedge clk);
      host_wr_done = 1;
      @(negedge clk);
      host_wr_done = 0;
      repeat (3) @(negedge clk);
      chk("t4_ignored", busy, 0);

      // level-held done; fresh edge lands in the timeout cycle
      req0 = 1; id0 = 8'h22;
      wait_for(0, 5, "t5_strobe1", n);
      repeat (3) @(negedge clk);
      host_wr_done = 1;
      @(negedge clk);
      chk("t5_done1st", done0, 1);
      wait_for(0, 5, "t5_strobe2", n);
      for (int j = 1; j <= 101; j++) begin
         @(negedge clk);
         if (j < 101) chk("t5_nodone", done0, 0);
         if (j == 99) host_wr_done = 0;
         if (j == 100) host_wr_done = 1;
      end
      chk("t5_done2nd", done0, 1);
      chk("t5_err_prio", err0, 0);
      req0 = 0;
      @(negedge clk);
      host_wr_done = 0;

      // reset during WAIT with requester 1 pending
      req0 = 1; id0 = 8'h33;
      wait_for(0, 5, "t6_strobe0", n);
      req1 = 1; rw1 = 1; id1 = 8'h44; addr1 = 8'h55;
      repeat (4) @(negedge clk);
      rst = 1;
      req0 = 0;
      @(negedge clk);
      rst = 0;
      chk("t6_busy", busy, 0);
      chk("t6_done0", done0, 0);
      chk("t6_id", host_id, 0);
      wait_for(1, 5, "t6_strobe1", n);
      chk("t6_id1", host_id, 8'h44);
      repeat (2) @(negedge clk);
      host_rd_data = 8'h7E;
      host_rd_done = 1;
      @(negedge clk);
      chk("t6_done1", done1, 1);
      chk("t6_rdata", rdata, 8'h7E);
      req1 = 0;
      @(negedge clk);
      host_rd_done = 0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
